// File: rtl/reg_access_ctrl.sv
// Command/response front-end for a register file: one transaction at a time, all outputs registered.
// Write: strobe N+1, response N+2. Read: strobe N+1, capture N+2, response N+3. Response held until RspReady.
module reg_access_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic             CmdWrite,
  input  logic [ADDR-1:0]  CmdAddr,
  input  logic [WIDTH-1:0] CmdData,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspData,
  output logic             RspErr,
  output logic [7:0]       ErrCnt,
  output logic [ADDR-1:0]  RfAddress,
  output logic             RfWrEn,
  output logic             RfRdEn,
  output logic [WIDTH-1:0] RfWrData,
  input  logic [WIDTH-1:0] RfRdData
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // One extra bit so DEPTH == 2**ADDR still compares correctly.
  localparam logic [ADDR:0] DEPTH_EXT = (ADDR+1)'(DEPTH);

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_write_q, cmd_write_d;
  logic             cmd_err_q, cmd_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [ADDR-1:0]  rf_addr_q, rf_addr_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic             rf_rd_en_q, rf_rd_en_d;
  logic [WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic             addr_oor;

  assign addr_oor = ({1'b0, CmdAddr} >= DEPTH_EXT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    cmd_write_d  = cmd_write_q;
    cmd_err_d    = cmd_err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    err_cnt_d    = err_cnt_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // Strobes are decided at accept so they appear registered in the ISSUE cycle.
        if (CmdValid && cmd_ready_q) begin
          state_d      = ISSUE;
          cmd_ready_d  = 1'b0;
          cmd_write_d  = CmdWrite;
          cmd_err_d    = addr_oor;
          rf_addr_d    = CmdAddr;
          rf_wr_data_d = CmdData;
          rf_wr_en_d   = CmdWrite && !addr_oor;
          rf_rd_en_d   = !CmdWrite && !addr_oor;
        end
      end
      ISSUE: begin
        if (cmd_err_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (cmd_write_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = RfRdData;
      end
      RESP: begin
        if (RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cmd_ready_q  <= 1'b1;
      cmd_write_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      err_cnt_q    <= '0;
      rf_addr_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_wr_data_q <= '0;
    end else begin
      cmd_ready_q  <= cmd_ready_d;
      cmd_write_q  <= cmd_write_d;
      cmd_err_q    <= cmd_err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      err_cnt_q    <= err_cnt_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign CmdReady  = cmd_ready_q;
  assign RspValid  = rsp_valid_q;
  assign RspErr    = rsp_err_q;
  assign RspData   = rsp_data_q;
  assign ErrCnt    = err_cnt_q;
  assign RfAddress = rf_addr_q;
  assign RfWrEn    = rf_wr_en_q;
  assign RfRdEn    = rf_rd_en_q;
  assign RfWrData  = rf_wr_data_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: table of single transactions, then streaming, saturation and reset sequences.
module tb_reg_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CmdValid;
  logic        CmdReady;
  logic        CmdWrite;
  logic [3:0]  CmdAddr;
  logic [15:0] CmdData;
  logic        RspValid;
  logic        RspReady;
  logic [15:0] RspData;
  logic        RspErr;
  logic [7:0]  ErrCnt;
  logic [3:0]  RfAddress;
  logic        RfWrEn;
  logic        RfRdEn;
  logic [15:0] RfWrData;
  logic [15:0] RfRdData;

  reg_access_ctrl #(.WIDTH(16), .DEPTH(8), .ADDR(4)) dut (
    .CLK(CLK), .RST(RST),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdAddr(CmdAddr), .CmdData(CmdData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
    .RspErr(RspErr), .ErrCnt(ErrCnt),
    .RfAddress(RfAddress), .RfWrEn(RfWrEn), .RfRdEn(RfRdEn),
    .RfWrData(RfWrData), .RfRdData(RfRdData)
  );

  always #5 CLK = ~CLK;

  // Register file: read data appears the cycle after RfRdEn.
  logic [15:0] rf_mem [16];
  logic [15:0] rf_rd_q;
  always @(posedge CLK) begin
    if (RfWrEn) rf_mem[RfAddress] <= RfWrData;
    if (RfRdEn) rf_rd_q <= rf_mem[RfAddress];
  end
  assign RfRdData = rf_rd_q;

  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int rspv_cnt = 0;
  logic [16:0] rsp_q [$];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RfWrEn) wr_cnt <= wr_cnt + 1;
    if (RfRdEn) rd_cnt <= rd_cnt + 1;
    if (RfWrEn && RfRdEn) both_cnt <= both_cnt + 1;
    if (RspValid) rspv_cnt <= rspv_cnt + 1;
    if (RspValid && RspReady) rsp_q.push_back({RspErr, RspData});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  a;
    logic [15:0] d;
    int          hold;
    logic [15:0] exp_d;
    logic        err;
    int          lat;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic run_vec(input int idx, input vec_t v);
    int wr0, rd0, k;
    logic exp_wr, exp_rd;
    exp_wr = v.w && !v.err;
    exp_rd = !v.w && !v.err;
    CmdWrite = v.w; CmdAddr = v.a; CmdData = v.d; CmdValid = 1'b1; RspReady = 1'b0;
    k = 0;
    while (!CmdReady && k < 20) begin @(posedge CLK); #1; k++; end
    if (!CmdReady) timeout($sformatf("vec%0d accept", idx));
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(posedge CLK); #1;
    // Garbage while not ready must be ignored.
    CmdWrite = ~v.w; CmdAddr = v.a ^ 4'd5; CmdData = ~v.d;
    chk($sformatf("vec%0d wren", idx), 32'(RfWrEn), 32'(exp_wr));
    chk($sformatf("vec%0d rden", idx), 32'(RfRdEn), 32'(exp_rd));
    chk($sformatf("vec%0d rfaddr", idx), 32'(RfAddress), 32'(v.a));
    if (v.w) chk($sformatf("vec%0d rfwdata", idx), 32'(RfWrData), 32'(v.d));
    k = 1;
    while (!RspValid && k < 10) begin @(posedge CLK); #1; k++; end
    chk($sformatf("vec%0d latency", idx), 32'(k), 32'(v.lat));
    chk($sformatf("vec%0d data", idx), 32'(RspData), 32'(v.exp_d));
    chk($sformatf("vec%0d err", idx), 32'(RspErr), 32'(v.err));
    chk($sformatf("vec%0d errcnt", idx), 32'(ErrCnt), 32'(v.cnt));
    for (int c = 0; c < v.hold; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("vec%0d hold%0d valid", idx, c), 32'(RspValid), 32'd1);
      chk($sformatf("vec%0d hold%0d data", idx, c), 32'(RspData), 32'(v.exp_d));
      chk($sformatf("vec%0d hold%0d cmdready", idx, c), 32'(CmdReady), 32'd0);
    end
    RspReady = 1'b1;
    @(posedge CLK); #1;
    RspReady = 1'b0; CmdValid = 1'b0;
    chk($sformatf("vec%0d valid cleared", idx), 32'(RspValid), 32'd0);
    chk($sformatf("vec%0d cmdready back", idx), 32'(CmdReady), 32'd1);
    chk($sformatf("vec%0d rfaddr held", idx), 32'(RfAddress), 32'(v.a));
    chk($sformatf("vec%0d rfwdata held", idx), 32'(RfWrData), 32'(v.d));
    chk($sformatf("vec%0d wr strobes", idx), 32'(wr_cnt - wr0), 32'(exp_wr));
    chk($sformatf("vec%0d rd strobes", idx), 32'(rd_cnt - rd0), 32'(exp_rd));
  endtask

  // Offer a command with RspReady tied high; returns the cycle stamp of the accept edge.
  task automatic b2b(input logic w, input logic [3:0] a, input logic [15:0] d, output int acc);
    int k;
    CmdWrite = w; CmdAddr = a; CmdData = d; CmdValid = 1'b1;
    k = 0;
    while (!CmdReady && k < 20) begin @(posedge CLK); #1; k++; end
    if (!CmdReady) timeout("b2b accept");
    @(posedge CLK); #1;
    acc = cyc;
    CmdValid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 20) begin @(posedge CLK); #1; k++; end
    if (rsp_q.size() < n) timeout("drain responses");
  endtask

  initial begin
    int acc [10];
    int wr0, rd0, rv0, nok;
    logic [15:0] exp_rd;

    vecs[0]  = '{1'b1, 4'd1,  16'h001D, 0, 16'h0000, 1'b0, 2, 8'd0};
    vecs[1]  = '{1'b0, 4'd1,  16'h0000, 0, 16'h001D, 1'b0, 3, 8'd0};
    vecs[2]  = '{1'b1, 4'd3,  16'h00DB, 0, 16'h0000, 1'b0, 2, 8'd0};
    vecs[3]  = '{1'b0, 4'd3,  16'h0000, 5, 16'h00DB, 1'b0, 3, 8'd0};
    vecs[4]  = '{1'b0, 4'd9,  16'h0000, 0, 16'h0000, 1'b1, 2, 8'd1};
    vecs[5]  = '{1'b1, 4'd15, 16'h1234, 0, 16'h0000, 1'b1, 2, 8'd2};
    vecs[6]  = '{1'b1, 4'd7,  16'hFFFF, 0, 16'h0000, 1'b0, 2, 8'd2};
    vecs[7]  = '{1'b0, 4'd7,  16'h5A5A, 0, 16'hFFFF, 1'b0, 3, 8'd2};
    vecs[8]  = '{1'b1, 4'd0,  16'h8001, 1, 16'h0000, 1'b0, 2, 8'd2};
    vecs[9]  = '{1'b0, 4'd0,  16'h0000, 0, 16'h8001, 1'b0, 3, 8'd2};
    vecs[10] = '{1'b0, 4'd8,  16'h0000, 0, 16'h0000, 1'b1, 2, 8'd3};
    vecs[11] = '{1'b1, 4'd3,  16'hBEEF, 2, 16'h0000, 1'b0, 2, 8'd3};
    vecs[12] = '{1'b0, 4'd3,  16'h0000, 0, 16'hBEEF, 1'b0, 3, 8'd3};

    RST = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b1; CmdAddr = 4'd2; CmdData = 16'hAAAA; RspReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset cmdready", 32'(CmdReady), 32'd1);
    chk("reset rspvalid", 32'(RspValid), 32'd0);
    chk("reset rsperr", 32'(RspErr), 32'd0);
    chk("reset rspdata", 32'(RspData), 32'd0);
    chk("reset errcnt", 32'(ErrCnt), 32'd0);
    chk("reset rfaddr", 32'(RfAddress), 32'd0);
    chk("reset rfwdata", 32'(RfWrData), 32'd0);
    chk("reset strobes", 32'({RfWrEn, RfRdEn}), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Back-to-back writes then reads, RspReady held high throughout.
    RspReady = 1'b1;
    rsp_q.delete();
    for (int i = 0; i < 10; i++) b2b(1'b1, 4'(i % 8), 16'hA000 + 16'(i), acc[i]);
    for (int i = 1; i < 10; i++) chk($sformatf("b2b wr cadence %0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
    drain(10);
    rsp_q.delete();
    for (int i = 0; i < 10; i++) b2b(1'b0, 4'(i % 8), 16'h0000, acc[i]);
    for (int i = 1; i < 10; i++) chk($sformatf("b2b rd cadence %0d", i), 32'(acc[i] - acc[i-1]), 32'd4);
    drain(10);
    for (int i = 0; i < 10; i++) begin
      exp_rd = ((i % 8) < 2) ? 16'hA008 + 16'(i % 8) : 16'hA000 + 16'(i % 8);
      if (i < rsp_q.size()) chk($sformatf("b2b rd data %0d", i), 32'(rsp_q[i]), 32'({1'b0, exp_rd}));
    end

    // 256 more errored commands on top of the 3 already seen: counter must stick at 255.
    rsp_q.delete();
    wr0 = wr_cnt; rd0 = rd_cnt;
    for (int i = 0; i < 256; i++) b2b(i[0], (i % 3 == 0) ? 4'd9 : ((i % 3 == 1) ? 4'd8 : 4'd15), 16'h7777, acc[0]);
    drain(256);
    chk("sat errcnt", 32'(ErrCnt), 32'd255);
    chk("sat rsp count", 32'(rsp_q.size()), 32'd256);
    nok = 0;
    foreach (rsp_q[i]) if (rsp_q[i] != 17'h10000) nok++;
    chk("sat rsp err/data", 32'(nok), 32'd0);
    chk("sat no strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    RspReady = 1'b0;

    // Reset coinciding with an offered command: nothing accepted, counter cleared.
    CmdWrite = 1'b1; CmdAddr = 4'd2; CmdData = 16'h1111; CmdValid = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; CmdValid = 1'b0;
    chk("rst-accept wren", 32'(RfWrEn), 32'd0);
    chk("rst-accept cmdready", 32'(CmdReady), 32'd1);
    chk("rst-accept errcnt", 32'(ErrCnt), 32'd0);
    @(posedge CLK); #1;
    chk("rst-accept wren next", 32'(RfWrEn), 32'd0);

    // Reset while in CAPTURE: response must be discarded.
    CmdWrite = 1'b0; CmdAddr = 4'd3; CmdData = 16'h0000; CmdValid = 1'b1;
    @(posedge CLK); #1;
    CmdValid = 1'b0;
    chk("capture-rst issue rden", 32'(RfRdEn), 32'd1);
    @(posedge CLK); #1;
    chk("capture-rst in capture rden", 32'(RfRdEn), 32'd0);
    chk("capture-rst in capture valid", 32'(RspValid), 32'd0);
    RspReady = 1'b1; RST = 1'b1;
    rv0 = rspv_cnt;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("capture-rst cmdready", 32'(CmdReady), 32'd1);
    chk("capture-rst rspdata", 32'(RspData), 32'd0);
    chk("capture-rst strobes", 32'({RfWrEn, RfRdEn}), 32'd0);
    chk("capture-rst rfaddr", 32'(RfAddress), 32'd0);
    repeat (6) @(posedge CLK);
    #1;
    chk("capture-rst rspvalid never", 32'(rspv_cnt - rv0), 32'd0);
    chk("capture-rst still idle", 32'(CmdReady), 32'd1);
    RspReady = 1'b0;

    chk("wr/rd never together", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
